sumador_acumulador_display_mux: RTL and testbench
=================================================

# sumador_acumulador_display_mux

Parametrised, registered add/subtract/accumulate unit with a time-multiplexed hexadecimal 7-segment display driver. It is the sequential successor to the team's 4-bit adder-with-display: width is a parameter, operations are strobed and registered, and all result digits are scanned onto one shared segment bus. It sits between the board switches/buttons and the multi-digit display.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 4..32.
- SCAN_DIV, 50000: clock cycles each digit stays enabled; minimum 2.
- DIGITS, (WIDTH+3)/4: derived local constant; not overridable.

- clk  in  1  rising-edge clock (one clock domain only).
- rst_n  in  1  asynchronous, active-low reset.
- X  in  WIDTH  operand A.
- Y  in  WIDTH  operand B (ignored in accumulate/clear).
- Modo  in  2  00 add X+Y, 01 sub X−Y, 10 accumulate Resultado+X, 11 clear.
- Valido  in  1  operation strobe, sampled each rising edge.
- Resultado  out  WIDTH  registered result.
- Carry  out  1  add/acc: carry-out; sub: borrow (1 when X<Y unsigned).
- Overflow  out  1  two's-complement overflow of the last operation.
- Listo  out  1  high for exactly the cycle after each accepted Valido.
- Anodos  out  DIGITS  digit enables, active-low, one-hot-low.
- Segmentos  out  7  {g,f,e,d,c,b,a}, active-low.

## Operation
- Valido=1 at an edge: operation per Modo executes; Resultado, Carry, Overflow, Listo updated on that edge. Valido=0: all hold, Listo=0.
- Arithmetic is WIDTH+1 bits internally; Resultado = low WIDTH bits, Carry = bit WIDTH (inverted for sub).
- Overflow: add/acc = operands same sign and result sign differs; sub = operand signs differ and result sign ≠ sign of X.
- Accumulate operands are current Resultado and X; Resultado wraps modulo 2^WIDTH.
- Clear: Resultado=0, Carry=0, Overflow=0, Listo pulses.
- Back-to-back Valido: each accepted, Listo stays high continuously.
- Scanner: prescaler counts 0..SCAN_DIV−1; on terminal count it returns to 0 and digit index advances, wrapping DIGITS−1→0.
- Digit k shows Resultado[4k+3:4k]; missing upper bits of the top digit are zero.
- Reset values: Resultado=0, Carry=0, Overflow=0, Listo=0, prescaler=0, index=0, Anodos=~1 (digit 0 on), Segmentos=7'b1000000 ("0").
- Reset asserted mid-operation: all registers go to reset values immediately; a Valido coincident with reset release edge is ignored.

## Timing
- Result latency: 1 cycle (Valido at edge t → Resultado/flags/Listo valid after edge t).
- Anodos and Segmentos are registered together from the index and current Resultado: 1-cycle lag behind an index or Resultado change; never mismatched with each other.
- Each digit enabled for exactly SCAN_DIV cycles; full refresh period DIGITS×SCAN_DIV cycles.
- No combinational path from inputs to outputs.

## Structure
- Shared package/include sumador_pkg: Modo codes (MODO_SUMA, MODO_RESTA, MODO_ACUM, MODO_BORRAR), active-low segment constants for 0–F, SEG_APAGADO.
- One sub-module: hex_a_7seg (combinational 4-bit → 7-segment active-low decoder), instanced once on the muxed nibble.
- Top holds operation register, prescaler, index counter and output registers.

## Test plan
- WIDTH=8: add X=0xFF,Y=0x01 → Resultado=0x00, Carry=1, Overflow=0; add 0x7F+0x01 → 0x80, Carry=0, Overflow=1.
- Sub 0x10−0x20 → 0xF0, Carry=1, Overflow=0; sub 0x80−0x01 → 0x7F, Carry=0, Overflow=1.
- Clear, then Modo=10, X=0x05, Valido high 3 consecutive cycles → Resultado 0x05, 0x0A, 0x0F; Listo high 3 cycles then 0.
- SCAN_DIV=4, Resultado=0x3C: Anodos=2'b10 with Segmentos=7'b1000110 for 4 cycles, then 2'b01 with 7'b0110000 for 4 cycles, repeating.
- WIDTH=6 (DIGITS=2), Resultado=0x3F: top digit shows 3 (7'b0110000), not F.
- rst_n low mid-scan while Valido=1 → all outputs immediately at reset values; after release, first index advance exactly SCAN_DIV cycles later.

Source files
------------

// File: rtl/sumador_pkg.sv
// Shared definitions for the add/subtract/accumulate unit and its display:
// operation codes and active-low segment patterns ({g,f,e,d,c,b,a}).
package sumador_pkg;

  // Operation selected by Modo when Valido is sampled high
  typedef enum logic [1:0] {
    MODO_SUMA   = 2'b00,  // X + Y
    MODO_RESTA  = 2'b01,  // X - Y
    MODO_ACUM   = 2'b10,  // Resultado + X
    MODO_BORRAR = 2'b11   // Resultado = 0, flags cleared
  } modo_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // All segments dark
  localparam logic [6:0] SEG_APAGADO = 7'b1111111;

endpackage

// File: rtl/hex_a_7seg.sv
// Combinational hexadecimal digit to active-low 7-segment decoder.
module hex_a_7seg
  import sumador_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segmentos
);

  // Look up the glyph for the 4-bit value
  always_comb begin
    segmentos = SEG_APAGADO;
    case (nibble)
      4'h0: segmentos = SEG_0;
      4'h1: segmentos = SEG_1;
      4'h2: segmentos = SEG_2;
      4'h3: segmentos = SEG_3;
      4'h4: segmentos = SEG_4;
      4'h5: segmentos = SEG_5;
      4'h6: segmentos = SEG_6;
      4'h7: segmentos = SEG_7;
      4'h8: segmentos = SEG_8;
      4'h9: segmentos = SEG_9;
      4'hA: segmentos = SEG_A;
      4'hB: segmentos = SEG_B;
      4'hC: segmentos = SEG_C;
      4'hD: segmentos = SEG_D;
      4'hE: segmentos = SEG_E;
      4'hF: segmentos = SEG_F;
      default: segmentos = SEG_APAGADO;
    endcase
  end

endmodule

// File: rtl/sumador_acumulador_display_mux.sv
// Registered add/subtract/accumulate unit whose result is scanned, one hex
// digit at a time, onto a shared active-low 7-segment bus.
module sumador_acumulador_display_mux
  import sumador_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int SCAN_DIV = 50000,
  localparam int DIGITS   = (WIDTH + 3) / 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  X,
  input  logic [WIDTH-1:0]  Y,
  input  logic [1:0]        Modo,
  input  logic              Valido,
  output logic [WIDTH-1:0]  Resultado,
  output logic              Carry,
  output logic              Overflow,
  output logic              Listo,
  output logic [DIGITS-1:0] Anodos,
  output logic [6:0]        Segmentos
);

  localparam int MSB   = WIDTH - 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Arithmetic datapath
  logic [WIDTH:0]      sum_ext;
  logic [WIDTH-1:0]    res_next;
  logic                carry_next;
  logic                ovf_next;

  logic [WIDTH-1:0]    resultado_reg;
  logic                carry_reg;
  logic                overflow_reg;
  logic                listo_reg;

  // Scanner
  logic [PRE_W-1:0]    prescaler_reg;
  logic [PRE_W-1:0]    prescaler_next;
  logic [IDX_W-1:0]    index_reg;
  logic [IDX_W-1:0]    index_next;
  logic                terminal;

  // Display path
  logic [4*DIGITS-1:0] res_pad;
  logic [3:0]          nibbles [DIGITS];
  logic [3:0]          nibble_sel;
  logic [DIGITS-1:0]   anodos_next;
  logic [6:0]          seg_next;
  logic [DIGITS-1:0]   anodos_reg;
  logic [6:0]          segmentos_reg;

  // Compute the candidate result and flags for the selected operation.
  // Subtraction is X + ~Y + 1; its carry-out is the inverse of the borrow.
  always_comb begin
    sum_ext    = '0;
    res_next   = '0;
    carry_next = 1'b0;
    ovf_next   = 1'b0;
    case (Modo)
      MODO_SUMA: begin
        sum_ext    = {1'b0, X} + {1'b0, Y};
        res_next   = sum_ext[WIDTH-1:0];
        carry_next = sum_ext[WIDTH];
        ovf_next   = (X[MSB] == Y[MSB]) && (sum_ext[MSB] != X[MSB]);
      end
      MODO_RESTA: begin
        sum_ext    = {1'b0, X} + {1'b0, ~Y} + (WIDTH+1)'(1);
        res_next   = sum_ext[WIDTH-1:0];
        carry_next = ~sum_ext[WIDTH];
        ovf_next   = (X[MSB] != Y[MSB]) && (sum_ext[MSB] != X[MSB]);
      end
      MODO_ACUM: begin
        sum_ext    = {1'b0, resultado_reg} + {1'b0, X};
        res_next   = sum_ext[WIDTH-1:0];
        carry_next = sum_ext[WIDTH];
        ovf_next   = (resultado_reg[MSB] == X[MSB]) && (sum_ext[MSB] != resultado_reg[MSB]);
      end
      default: begin
        sum_ext    = '0;
        res_next   = '0;
        carry_next = 1'b0;
        ovf_next   = 1'b0;
      end
    endcase
  end

  // Operation register: update on an accepted strobe, Listo echoes the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resultado_reg <= '0;
      carry_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      listo_reg     <= 1'b0;
    end else begin
      listo_reg <= Valido;
      if (Valido) begin
        resultado_reg <= res_next;
        carry_reg     <= carry_next;
        overflow_reg  <= ovf_next;
      end
    end
  end

  // Prescaler terminal count advances the digit index, wrapping at the top digit
  always_comb begin
    terminal       = (prescaler_reg == PRE_W'(SCAN_DIV - 1));
    prescaler_next = prescaler_reg + PRE_W'(1);
    index_next     = index_reg;
    if (terminal) begin
      prescaler_next = '0;
      if (index_reg == IDX_W'(DIGITS - 1)) begin
        index_next = '0;
      end else begin
        index_next = index_reg + IDX_W'(1);
      end
    end
  end

  // Scanner counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_reg <= '0;
      index_reg     <= '0;
    end else begin
      prescaler_reg <= prescaler_next;
      index_reg     <= index_next;
    end
  end

  // Zero-extend the result to whole nibbles so the top digit shows missing bits as 0
  always_comb begin
    res_pad              = '0;
    res_pad[WIDTH-1:0]   = resultado_reg;
  end

  // Split into digits and build the one-hot-low enable for the current index
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nibbles[gi]     = res_pad[4*gi +: 4];
      assign anodos_next[gi] = (index_reg != IDX_W'(gi));
    end
  endgenerate

  // Pick the nibble belonging to the digit currently being driven
  always_comb begin
    nibble_sel = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (index_reg == IDX_W'(k)) begin
        nibble_sel = nibbles[k];
      end
    end
  end

  hex_a_7seg u_hex_a_7seg (
    .nibble    (nibble_sel),
    .segmentos (seg_next)
  );

  // Register enables and segments together so they never disagree
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anodos_reg    <= ~DIGITS'(1);
      segmentos_reg <= SEG_0;
    end else begin
      anodos_reg    <= anodos_next;
      segmentos_reg <= seg_next;
    end
  end

  assign Resultado = resultado_reg;
  assign Carry     = carry_reg;
  assign Overflow  = overflow_reg;
  assign Listo     = listo_reg;
  assign Anodos    = anodos_reg;
  assign Segmentos = segmentos_reg;

endmodule

// File: tb/tb_sumador_acumulador_display_mux.sv
// Bench for sumador_acumulador_display_mux: an 8-bit instance (SCAN_DIV=4)
// and a 6-bit instance (SCAN_DIV=3) share control inputs and are checked
// every cycle against an arithmetic model, plus hand-computed expectations.
module tb_sumador_acumulador_display_mux;

  localparam int W0 = 8, W1 = 6, SD0 = 4, SD1 = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] x8, y8;
  logic [5:0] x6, y6;
  logic [1:0] modo;
  logic       valido;

  logic [7:0] res8;
  logic       c8, v8, l8;
  logic [1:0] an8;
  logic [6:0] seg8;
  logic [5:0] res6;
  logic       c6, v6, l6;
  logic [1:0] an6;
  logic [6:0] seg6;

  int errors = 0;
  int checks = 0;

  // Reference glyphs {g,f,e,d,c,b,a}, active-low, for 0..F
  logic [6:0] seg_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model state per instance (index 0: 8-bit, 1: 6-bit)
  int m_res [2];
  int m_c   [2];
  int m_v   [2];
  int m_l   [2];
  int m_cnt [2];
  int m_an  [2];
  int m_seg [2];

  sumador_acumulador_display_mux #(.WIDTH(W0), .SCAN_DIV(SD0)) dut8 (
    .clk(clk), .rst_n(rst_n), .X(x8), .Y(y8), .Modo(modo), .Valido(valido),
    .Resultado(res8), .Carry(c8), .Overflow(v8), .Listo(l8),
    .Anodos(an8), .Segmentos(seg8));

  sumador_acumulador_display_mux #(.WIDTH(W1), .SCAN_DIV(SD1)) dut6 (
    .clk(clk), .rst_n(rst_n), .X(x6), .Y(y6), .Modo(modo), .Valido(valido),
    .Resultado(res6), .Carry(c6), .Overflow(v6), .Listo(l6),
    .Anodos(an6), .Segmentos(seg6));

  always #5 clk = ~clk;

  function automatic int w_of(input int i);
    return (i == 0) ? W0 : W1;
  endfunction

  function automatic int sd_of(input int i);
    return (i == 0) ? SD0 : SD1;
  endfunction

  function automatic int sgn(input int v, input int w);
    return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
  endfunction

  function automatic int op_res(input int w, input int md, input int a, input int b);
    int mask = (1 << w) - 1;
    case (md)
      0, 2:    return (a + b) & mask;
      1:       return (a - b) & mask;
      default: return 0;
    endcase
  endfunction

  function automatic int op_c(input int w, input int md, input int a, input int b);
    case (md)
      0, 2:    return ((a + b) >= (1 << w)) ? 1 : 0;
      1:       return (a < b) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int op_v(input int w, input int md, input int a, input int b);
    int s;
    int lim = 1 << (w - 1);
    case (md)
      0, 2:    s = sgn(a, w) + sgn(b, w);
      1:       s = sgn(a, w) - sgn(b, w);
      default: return 0;
    endcase
    return (s >= lim || s < -lim) ? 1 : 0;
  endfunction

  // First operand: running result when accumulating, else X
  function automatic int opa(input int i);
    int xi = (i == 0) ? int'(x8) : int'(x6);
    return (modo == 2'b10) ? m_res[i] : xi;
  endfunction

  function automatic int opb(input int i);
    int xi = (i == 0) ? int'(x8) : int'(x6);
    int yi = (i == 0) ? int'(y8) : int'(y6);
    return (modo == 2'b10) ? xi : yi;
  endfunction

  // Digit being shown after cnt post-reset edges: cnt/SCAN_DIV mod 2 digits
  function automatic int disp_an(input int cnt, input int sd);
    int idx = (cnt / sd) % 2;
    return 3 & ~(1 << idx);
  endfunction

  function automatic int disp_seg(input int res, input int cnt, input int sd);
    int idx = (cnt / sd) % 2;
    return int'(seg_tbl[(res >> (4 * idx)) & 15]);
  endfunction

  // Behavioural model of both instances
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_res[i] <= 0;
        m_c[i]   <= 0;
        m_v[i]   <= 0;
        m_l[i]   <= 0;
        m_cnt[i] <= 0;
        m_an[i]  <= 2;
        m_seg[i] <= 7'h40;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_an[i]  <= disp_an(m_cnt[i], sd_of(i));
        m_seg[i] <= disp_seg(m_res[i], m_cnt[i], sd_of(i));
        m_cnt[i] <= m_cnt[i] + 1;
        m_l[i]   <= valido ? 1 : 0;
        if (valido) begin
          m_res[i] <= op_res(w_of(i), int'(modo), opa(i), opb(i));
          m_c[i]   <= op_c(w_of(i), int'(modo), opa(i), opb(i));
          m_v[i]   <= op_v(w_of(i), int'(modo), opa(i), opb(i));
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("m8_res", int'(res8), m_res[0]);
    chk("m8_carry", int'(c8), m_c[0]);
    chk("m8_ovf", int'(v8), m_v[0]);
    chk("m8_listo", int'(l8), m_l[0]);
    chk("m8_anodos", int'(an8), m_an[0]);
    chk("m8_seg", int'(seg8), m_seg[0]);
    chk("m6_res", int'(res6), m_res[1]);
    chk("m6_carry", int'(c6), m_c[1]);
    chk("m6_ovf", int'(v6), m_v[1]);
    chk("m6_listo", int'(l6), m_l[1]);
    chk("m6_anodos", int'(an6), m_an[1]);
    chk("m6_seg", int'(seg6), m_seg[1]);
  endtask

  // Advance one cycle and compare everything against the model
  task automatic tick();
    @(negedge clk);
    cmp_all();
  endtask

  task automatic do_op(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
    modo   = m;
    x8     = a;
    y8     = b;
    x6     = a[5:0];
    y6     = b[5:0];
    valido = 1'b1;
    tick();
    valido = 1'b0;
    $display("op modo=%0d X=%02h Y=%02h -> Resultado=%02h Carry=%0b Overflow=%0b Listo=%0b",
             m, a, b, res8, c8, v8, l8);
  endtask

  int cnt_lo, cnt_hi, cnt6;

  initial begin
    rst_n  = 1'b0;
    valido = 1'b0;
    modo   = 2'b00;
    x8 = '0; y8 = '0; x6 = '0; y6 = '0;
    repeat (3) tick();
    chk("rst_res", int'(res8), 0);
    chk("rst_listo", int'(l8), 0);
    chk("rst_anodos", int'(an8), 2);
    chk("rst_seg", int'(seg8), 7'h40);
    rst_n = 1'b1;

    do_op(2'b00, 8'hFF, 8'h01);
    chk("add_ff_res", int'(res8), 8'h00);
    chk("add_ff_carry", int'(c8), 1);
    chk("add_ff_ovf", int'(v8), 0);
    chk("add_ff_listo", int'(l8), 1);
    tick();
    chk("idle_listo", int'(l8), 0);

    do_op(2'b00, 8'h7F, 8'h01);
    chk("add_7f_res", int'(res8), 8'h80);
    chk("add_7f_carry", int'(c8), 0);
    chk("add_7f_ovf", int'(v8), 1);

    do_op(2'b01, 8'h10, 8'h20);
    chk("sub_10_res", int'(res8), 8'hF0);
    chk("sub_10_borrow", int'(c8), 1);
    chk("sub_10_ovf", int'(v8), 0);

    do_op(2'b01, 8'h80, 8'h01);
    chk("sub_80_res", int'(res8), 8'h7F);
    chk("sub_80_borrow", int'(c8), 0);
    chk("sub_80_ovf", int'(v8), 1);

    do_op(2'b11, 8'h55, 8'h66);
    chk("clr_res", int'(res8), 0);
    chk("clr_carry", int'(c8), 0);
    chk("clr_listo", int'(l8), 1);

    // Three back-to-back accumulates of 5
    modo   = 2'b10;
    x8     = 8'h05;
    x6     = 6'h05;
    valido = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      $display("acc step %0d -> Resultado=%02h Listo=%0b", k, res8, l8);
      chk("acc_res", int'(res8), 5 * k);
      chk("acc_listo", int'(l8), 1);
    end
    valido = 1'b0;
    tick();
    chk("acc_end_listo", int'(l8), 0);
    chk("acc_end_res", int'(res8), 8'h0F);

    // Display scan: 8-bit shows 3C, 6-bit shows 3F
    modo   = 2'b00;
    x8     = 8'h3C;
    y8     = 8'h00;
    x6     = 6'h3F;
    y6     = 6'h00;
    valido = 1'b1;
    tick();
    valido = 1'b0;
    repeat (2) tick();
    cnt_lo = 0; cnt_hi = 0; cnt6 = 0;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (an8 == 2'b10 && seg8 == 7'b1000110) cnt_lo++;
      if (an8 == 2'b01 && seg8 == 7'b0110000) cnt_hi++;
      if (an6 == 2'b01 && seg6 == 7'b0110000) cnt6++;
    end
    $display("scan: digit0 C cycles=%0d digit1 3 cycles=%0d w6 top 3 cycles=%0d",
             cnt_lo, cnt_hi, cnt6);
    chk("scan_d0_C", cnt_lo, 12);
    chk("scan_d1_3", cnt_hi, 12);
    chk("w6_top_3", cnt6, 12);

    // Asynchronous reset in the middle of a scan with a strobe pending
    modo   = 2'b00;
    x8     = 8'h01;
    y8     = 8'h01;
    valido = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    $display("async reset -> Resultado=%02h Anodos=%02b Segmentos=%07b", res8, an8, seg8);
    chk("arst_res", int'(res8), 0);
    chk("arst_listo", int'(l8), 0);
    chk("arst_anodos", int'(an8), 2);
    chk("arst_seg", int'(seg8), 7'h40);
    chk("arst_res6", int'(res6), 0);
    repeat (2) tick();
    valido = 1'b0;
    rst_n  = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (e == 4) chk("rel_anodos_hold", int'(an8), 2);
      if (e == 5) chk("rel_anodos_adv", int'(an8), 1);
    end
    chk("rel_res", int'(res8), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
